// File: rtl/ra_count_capture.sv
// ra_count_capture: iteration counter driven by the RA controller strobes,
// with capture of the final count into a valid/ack result register.
module ra_count_capture #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cntclr,
    input  logic             cnten,
    input  logic             done,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] result,
    output logic             valid,
    output logic             busy,
    output logic             ovf,
    output logic             lost
);
    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
    state_t state, state_nxt;
    logic             done_q, wrap, done_rise, run, cap, wrap_upd;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_upd;

    always_ff @(posedge clk or negedge clear)
        if (!clear) state <= IDLE;
        else        state <= state_nxt;

    always_comb
        state_nxt = cntclr ? COUNT :
                    (state == COUNT && done_rise) ? HOLD :
                    (state == HOLD && ack && valid) ? IDLE : state;

    always_comb begin
        busy      = state == COUNT;
        run       = state == COUNT;
        done_rise = done & ~done_q;
        cap       = run & done_rise & ~cntclr;
        sum       = {1'b0, count} + (CNT_W+1)'(1);
        cnt_upd   = (run & cnten) ? sum[CNT_W-1:0] : count;
        wrap_upd  = wrap | (run & cnten & sum[CNT_W]);
    end

    // Capture uses the post-increment count; a capture over an unacked result is dropped.
    always_ff @(posedge clk or negedge clear)
        if (!clear) begin
            done_q <= 1'b0;
            count  <= '0;
            wrap   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
            lost   <= 1'b0;
        end else begin
            done_q <= done;
            count  <= cntclr ? '0 : cnt_upd;
            wrap   <= cntclr ? 1'b0 : wrap_upd;
            if (cap && (!valid || ack)) begin
                result <= cnt_upd;
                ovf    <= wrap_upd;
            end
            valid <= cap | (valid & ~ack);
            lost  <= lost | (cap & valid & ~ack);
        end
endmodule

// File: tb/tb_ra_count_capture.sv
// tb_ra_count_capture: directed scenario tests for ra_count_capture.
module tb_ra_count_capture;
    logic       clk = 1'b0, clear = 1'b0;
    logic       cntclr = 1'b0, cnten = 1'b0, done = 1'b0, ack = 1'b0;
    logic [3:0] count, result;
    logic       valid, busy, ovf, lost;
    int         errors = 0, checks = 0;

    ra_count_capture #(.CNT_W(4)) dut (
        .clk(clk), .clear(clear), .cntclr(cntclr), .cnten(cnten), .done(done), .ack(ack),
        .count(count), .result(result), .valid(valid), .busy(busy), .ovf(ovf), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic c, input logic e, input logic d, input logic a);
        cntclr = c; cnten = e; done = d; ack = a;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({count, result, valid, busy, ovf, lost} !== 12'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", {count, result, valid, busy, ovf, lost});
        end
        @(negedge clk); clear = 1'b1;
    endtask

    task automatic test_idle_filter;
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        checks++;
        if (count !== 4'd0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_filter got count=%0d valid=%b busy=%b exp 0 0 0", count, valid, busy);
        end
    endtask

    task automatic test_basic;
        cyc(1, 0, 0, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        repeat (2) cyc(0, 1, 0, 0);
        checks++;
        if (count !== 4'd2 || valid !== 1'b0) begin
            errors++; $display("FAIL basic_count got count=%0d valid=%b exp 2 0", count, valid);
        end
        cyc(0, 0, 1, 0);
        checks++;
        if (valid !== 1'b1 || result !== 4'd2 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_capture got v=%b r=%0d o=%b b=%b exp 1 2 0 0", valid, result, ovf, busy);
        end
        repeat (2) cyc(0, 0, 1, 0);
        checks++;
        if (valid !== 1'b1 || result !== 4'd2 || lost !== 1'b0) begin
            errors++; $display("FAIL basic_single got v=%b r=%0d l=%b exp 1 2 0", valid, result, lost);
        end
        cyc(0, 0, 0, 1);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_ack got v=%b b=%b exp 0 0", valid, busy);
        end
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        checks++;
        if (valid !== 1'b0 || count !== 4'd2) begin
            errors++; $display("FAIL basic_idle got v=%b count=%0d exp 0 2", valid, count);
        end
    endtask

    task automatic test_wrap;
        cyc(1, 0, 0, 0);
        repeat (17) cyc(0, 1, 0, 0);
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", count); end
        cyc(0, 0, 1, 0);
        checks++;
        if (result !== 4'd1 || ovf !== 1'b1 || valid !== 1'b1) begin
            errors++; $display("FAIL wrap_capture got r=%0d o=%b v=%b exp 1 1 1", result, ovf, valid);
        end
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        checks++;
        if (result !== 4'd5 || ovf !== 1'b0 || valid !== 1'b1) begin
            errors++; $display("FAIL wrap_next got r=%0d o=%b v=%b exp 5 0 1", result, ovf, valid);
        end
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_simultaneous;
        cyc(1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        checks++;
        if (result !== 4'd3 || valid !== 1'b1 || count !== 4'd3) begin
            errors++; $display("FAIL sim_cnten_done got r=%0d v=%b c=%0d exp 3 1 3", result, valid, count);
        end
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        checks++;
        if (valid !== 1'b0 || count !== 4'd0 || busy !== 1'b1 || result !== 4'd3) begin
            errors++; $display("FAIL sim_clr_done got v=%b c=%0d b=%b r=%0d exp 0 0 1 3", valid, count, busy, result);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back;
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        checks++;
        if (result !== 4'd4 || valid !== 1'b1 || lost !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_drop got r=%0d v=%b l=%b b=%b exp 4 1 1 0", result, valid, lost, busy);
        end
        cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 1);
        checks++;
        if (result !== 4'd6 || valid !== 1'b1 || lost !== 1'b1) begin
            errors++; $display("FAIL bp_ack_same got r=%0d v=%b l=%b exp 6 1 1", result, valid, lost);
        end
        cyc(0, 0, 0, 1);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL bp_release got v=%b exp 0", valid); end
    endtask

    task automatic test_async_reset;
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        #3 clear = 1'b0;
        #1;
        checks++;
        if ({count, result, valid, busy, ovf, lost} !== 12'd0) begin
            errors++; $display("FAIL async_reset got=%h exp=0", {count, result, valid, busy, ovf, lost});
        end
        @(negedge clk); clear = 1'b1;
        repeat (2) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        checks++;
        if (count !== 4'd0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_after got c=%0d v=%b b=%b exp 0 0 0", count, valid, busy);
        end
    endtask

    initial begin
        test_reset;
        test_idle_filter;
        test_basic;
        test_wrap;
        test_simultaneous;
        test_back_to_back;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
